// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register for the MIPS datapath.
// Owns the PC, reads one instruction word at a time from instruction memory
// over a request/ready handshake, and hands the fetched word, its PC+4 and a
// valid bit to decode. Handles decode stalls with a one-entry skid buffer,
// beq redirects from execute, and memory wait states. No instruction is lost
// or duplicated.
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   stall          hazard unit: hold IF/ID contents this cycle
//   branch_taken   execute-stage beq taken; flushes IF/ID and redirects
//   branch_target  redirect address, valid with branch_taken
//   imem_req       read request; address held stable until imem_ready
//   imem_addr      read address (the PC register)
//   imem_ready     imem_rdata valid this cycle; completes the request
//   imem_rdata     instruction word
//   if_id_instr    registered instruction, 0 when invalid
//   if_id_pc4      registered PC+4 of that instruction, 0 when invalid
//   if_id_valid    IF/ID holds a real instruction
//   opcode         if_id_instr[31:26] for the main control decoder

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode
);

    // FETCH: normal fetching. HOLD: a word fetched during a stall is parked
    // in the skid buffer and no new request is issued. KILL: a read that a
    // branch made stale is still outstanding; wait for it and throw it away.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] pc_plus4;

    // 32-bit modulo increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state logic. Branch outranks stall everywhere; every path that
    // flushes loads an all-zero bubble into IF/ID.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc4_d     = buf_pc4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;

        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    if_id_instr_d = 32'd0;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                    if (imem_ready) begin
                        // Returned word is on the wrong path; drop it.
                        pc_d = branch_target;
                    end else begin
                        // Address must stay put until the stale read completes.
                        redirect_pc_d = branch_target;
                        state_d       = KILL;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = HOLD;
                    end else begin
                        if_id_instr_d = imem_rdata;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    if_id_instr_d = 32'd0;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                end
            end

            KILL: begin
                if_id_instr_d = 32'd0;
                if_id_pc4_d   = 32'd0;
                if_id_valid_d = 1'b0;
                if (branch_taken) begin
                    redirect_pc_d = branch_target;
                end
                if (imem_ready) begin
                    pc_d    = branch_taken ? branch_target : redirect_pc_q;
                    state_d = FETCH;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    buf_instr_d   = 32'd0;
                    buf_pc4_d     = 32'd0;
                    pc_d          = branch_target;
                    if_id_instr_d = 32'd0;
                    if_id_pc4_d   = 32'd0;
                    if_id_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (!stall) begin
                    if_id_instr_d = buf_instr_q;
                    if_id_pc4_d   = buf_pc4_q;
                    if_id_valid_d = 1'b1;
                    state_d       = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'd0;
            buf_instr_q   <= 32'd0;
            buf_pc4_q     <= 32'd0;
            if_id_instr_q <= 32'd0;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc4_q     <= buf_pc4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Request is suppressed during reset so an in-flight read is abandoned.
    assign imem_req    = !reset && (state_q != HOLD);
    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign opcode      = if_id_instr_q[31:26];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the MIPS datapath. Owns the PC, issues word reads to instruction memory over a ready handshake, and presents the fetched instruction, its PC+4 and a valid bit to the decode stage. The main control decoder consumes `opcode`. Handles downstream stall, beq redirect from execute, and memory wait states without losing or duplicating instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hazard unit: hold IF/ID contents this cycle.
- `branch_taken`  in  1  execute-stage beq resolved taken (Branch & Zero); flushes IF/ID.
- `branch_target`  in  32  redirect address, valid with `branch_taken`.
- `imem_req`  out  1  read request; address must stay stable while high until `imem_ready`.
- `imem_addr`  out  32  equals PC register.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; completes request.
- `imem_rdata`  in  32  instruction word.
- `if_id_instr`  out  32  registered instruction; 0 (nop) when invalid.
- `if_id_pc4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `opcode`  out  6  `if_id_instr[31:26]` to the control decoder.

## Operation
- Registers: `pc`, `if_id_*`, skid buffer (`buf_instr`, `buf_pc4`), `redirect_pc`, state ∈ {FETCH, HOLD, KILL}.
- Reset: pc=RESET_PC, state=FETCH, if_id_instr=0, if_id_pc4=0, if_id_valid=0, buffers 0. `imem_req`=0 while `reset` high. Reset mid-request abandons it; memory must tolerate a dropped request.
- `imem_req` = 1 in FETCH and KILL, 0 in HOLD. "Bubble" = instr 0, pc4 0, valid 0.
- Priority: reset > branch_taken > stall.
- FETCH:
  - branch & ready: pc←target, IF/ID←bubble, stay FETCH (data discarded).
  - branch & !ready: redirect_pc←target, IF/ID←bubble, →KILL.
  - ready & !stall: IF/ID←{rdata, pc+4, 1}; pc←pc+4.
  - ready & stall: buf←{rdata, pc+4}; pc←pc+4; IF/ID held; →HOLD.
  - !ready & stall: IF/ID held. !ready & !stall: IF/ID←bubble.
- KILL (outstanding read to be discarded): address unchanged; IF/ID←bubble every cycle. branch again: redirect_pc←new target. On ready: pc←redirect_pc (or same-cycle new target), →FETCH.
- HOLD: branch: drop buffer, pc←target, IF/ID←bubble, →FETCH. !stall: IF/ID←{buf, 1}, →FETCH. stall: hold all.
- PC arithmetic 32-bit modulo: 32'hFFFF_FFFC+4 = 0. Target used as given, no alignment check.

## Timing
- `imem_ready` in cycle N (no stall, no branch) → `if_id_valid`/instr at edge ending N, visible N+1.
- Zero-wait memory (ready same cycle as req): one instruction per cycle, addresses increment by 4 each cycle.
- First request: cycle after `reset` falls, address RESET_PC.
- Branch in cycle N with memory ready: `imem_addr`=target in N+1; IF/ID bubble N+1.
- Stall released in cycle M from HOLD: buffered instruction visible M+1; new request in M+1.
- `opcode` combinational from registered `if_id_instr`; no extra latency.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory returning rdata=addr: addresses 0x100,0x104,0x108 on consecutive cycles; if_id_pc4 0x104,0x108,0x10C one cycle later; valid=1; opcode=rdata[31:26].
- 2-cycle wait state per read, no stall: req stays high with stable address; valid pulses one cycle per instruction; bubbles in between.
- Stall held 3 cycles starting with ready: IF/ID unchanged 3 cycles, req low in HOLD, buffered word appears cycle after stall drops; sequence of pc4 has no gap or repeat.
- Branch to 0x40 while read outstanding (ready 2 cycles later): address held until ready, returned word never reaches IF/ID, next address 0x40.
- Branch to 0x80 during HOLD with stall high: buffer dropped, valid=0, next address 0x80; also branch+ready same cycle → address 0x80 next cycle.
- PC=0xFFFF_FFFC fetch → next address 0x0, if_id_pc4=0; reset asserted in KILL → outputs reset values next cycle, fetch restarts at RESET_PC.
